// File: rtl/pc_exception_ctrl.sv
// Exception sequencer for the PC source mux: passes main-control requests through in IDLE,
// and on an exception saves EPC, fetches the handler vector byte, then loads it into PC.
module pc_exception_ctrl #(
  parameter int MEM_LATENCY  = 2,
  parameter int VEC_OPCODE   = 253,
  parameter int VEC_OVERFLOW = 254,
  parameter int VEC_DIV0     = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  pc_src_req,
  input  logic        pc_write_req,
  input  logic        exc_opcode,
  input  logic        exc_overflow,
  input  logic        exc_div0,
  input  logic [31:0] pc_current,
  output logic [2:0]  pc_src_sel,
  output logic        pc_write,
  output logic [31:0] epc_out,
  output logic [1:0]  exc_cause,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, EXC_SAVE, MEM_WAIT, LOAD_PC} state_t;

  localparam logic [2:0] WAIT_LAST = 3'(MEM_LATENCY - 1);

  state_t      state_reg, state_next;
  logic [1:0]  pend_cause_reg;
  logic [1:0]  exc_cause_reg;
  logic [31:0] epc_reg;
  logic [2:0]  wait_cnt_reg;
  logic [1:0]  win_cause;
  logic [31:0] vec_addr;

  // Fixed priority: opcode > overflow > div0; 00 means no exception.
  always_comb begin
    win_cause = 2'b00;
    if (exc_opcode)        win_cause = 2'b01;
    else if (exc_overflow) win_cause = 2'b10;
    else if (exc_div0)     win_cause = 2'b11;
  end

  always_comb begin
    vec_addr = 32'(VEC_DIV0);
    case (pend_cause_reg)
      2'b01:   vec_addr = 32'(VEC_OPCODE);
      2'b10:   vec_addr = 32'(VEC_OVERFLOW);
      default: vec_addr = 32'(VEC_DIV0);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      pend_cause_reg <= 2'b00;
      exc_cause_reg  <= 2'b00;
      epc_reg        <= 32'd0;
      wait_cnt_reg   <= 3'd0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          wait_cnt_reg <= 3'd0;
          if (win_cause != 2'b00) pend_cause_reg <= win_cause;
        end
        EXC_SAVE: begin
          epc_reg       <= pc_current - 32'd4;
          exc_cause_reg <= pend_cause_reg;
          wait_cnt_reg  <= 3'd0;
        end
        MEM_WAIT: wait_cnt_reg <= wait_cnt_reg + 3'd1;
        default:  wait_cnt_reg <= 3'd0;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_src_sel = 3'b000;
    pc_write   = 1'b0;
    mem_addr   = 32'd0;
    mem_rd     = 1'b0;
    busy       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (win_cause != 2'b00) begin
          state_next = EXC_SAVE;
        end else begin
          pc_src_sel = pc_src_req;
          pc_write   = pc_write_req;
        end
      end
      EXC_SAVE: begin
        mem_addr   = vec_addr;
        mem_rd     = 1'b1;
        busy       = 1'b1;
        state_next = MEM_WAIT;
      end
      MEM_WAIT: begin
        mem_addr = vec_addr;
        mem_rd   = 1'b1;
        busy     = 1'b1;
        if (wait_cnt_reg == WAIT_LAST) state_next = LOAD_PC;
      end
      LOAD_PC: begin
        pc_src_sel = 3'b011;
        pc_write   = 1'b1;
        busy       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign epc_out   = epc_reg;
  assign exc_cause = exc_cause_reg;

endmodule

// File: tb/tb_pc_exception_ctrl.sv
// Directed bench for pc_exception_ctrl with MEM_LATENCY=2.
module tb_pc_exception_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  pc_src_req;
  logic        pc_write_req;
  logic        exc_opcode, exc_overflow, exc_div0;
  logic [31:0] pc_current;
  logic [2:0]  pc_src_sel;
  logic        pc_write;
  logic [31:0] epc_out;
  logic [1:0]  exc_cause;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_exception_ctrl #(.MEM_LATENCY(2), .VEC_OPCODE(253), .VEC_OVERFLOW(254), .VEC_DIV0(255)) dut (
    .clk(clk), .reset(reset), .pc_src_req(pc_src_req), .pc_write_req(pc_write_req),
    .exc_opcode(exc_opcode), .exc_overflow(exc_overflow), .exc_div0(exc_div0),
    .pc_current(pc_current), .pc_src_sel(pc_src_sel), .pc_write(pc_write),
    .epc_out(epc_out), .exc_cause(exc_cause), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .busy(busy)
  );

  // Samples n cycles starting with the cycle after the exception edge; optionally
  // injects exc_div0 + pc_write_req during cycle index inj.
  task automatic observe(input int n, input int inj, input logic [31:0] addr_exp,
                         output int b, output int m, output int ld, output int pw,
                         output int bad_addr);
    b = 0; m = 0; ld = 0; pw = 0; bad_addr = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == inj) begin
        exc_div0 = 1'b1; pc_write_req = 1'b1;
      end else if (i == inj + 1) begin
        exc_div0 = 1'b0; pc_write_req = 1'b0;
      end
      #1;
      if (busy) b++;
      if (mem_rd) begin
        m++;
        if (mem_addr !== addr_exp) bad_addr++;
      end
      if (pc_write) begin
        pw++;
        if (pc_src_sel === 3'b011) ld++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; pc_src_req = 3'b000; pc_write_req = 1'b0;
    exc_opcode = 1'b0; exc_overflow = 1'b0; exc_div0 = 1'b0; pc_current = 32'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    pc_src_req = 3'b001; pc_write_req = 1'b1;
    #1;
    checks++;
    if (pc_src_sel !== 3'b001 || pc_write !== 1'b1) begin
      errors++; $display("FAIL reset_passthru: sel=%b wr=%b expected sel=001 wr=1", pc_src_sel, pc_write);
    end
    checks++;
    if (epc_out !== 32'd0 || exc_cause !== 2'b00 || busy !== 1'b0 || mem_rd !== 1'b0 || mem_addr !== 32'd0) begin
      errors++; $display("FAIL reset_state: epc=%h cause=%b busy=%b rd=%b addr=%h expected all 0",
                         epc_out, exc_cause, busy, mem_rd, mem_addr);
    end
    $display("reset: sel=%b wr=%b epc=%h cause=%b busy=%b", pc_src_sel, pc_write, epc_out, exc_cause, busy);
    @(negedge clk);
    pc_src_req = 3'b000; pc_write_req = 1'b0;
  endtask

  task automatic test_overflow();
    int b, m, ld, pw, bad;
    @(negedge clk);
    pc_current = 32'h0000_0040; exc_overflow = 1'b1; pc_src_req = 3'b010; pc_write_req = 1'b1;
    #1;
    checks++;
    if (pc_write !== 1'b0 || pc_src_sel !== 3'b000 || busy !== 1'b0) begin
      errors++; $display("FAIL ovf_entry: wr=%b sel=%b busy=%b expected wr=0 sel=000 busy=0", pc_write, pc_src_sel, busy);
    end
    @(posedge clk); #1;
    exc_overflow = 1'b0; pc_src_req = 3'b000; pc_write_req = 1'b0;
    observe(6, -10, 32'd254, b, m, ld, pw, bad);
    checks++;
    if (b != 4 || m != 3 || ld != 1 || pw != 1 || bad != 0) begin
      errors++; $display("FAIL ovf_seq: busy=%0d rd=%0d load=%0d wr=%0d badaddr=%0d expected 4 3 1 1 0", b, m, ld, pw, bad);
    end
    checks++;
    if (epc_out !== 32'h0000_003C || exc_cause !== 2'b10) begin
      errors++; $display("FAIL ovf_epc: epc=%h cause=%b expected 0000003c 10", epc_out, exc_cause);
    end
    $display("overflow: busy=%0d rd=%0d load=%0d epc=%h cause=%b", b, m, ld, epc_out, exc_cause);
  endtask

  task automatic test_priority();
    int b, m, ld, pw, bad;
    @(negedge clk);
    pc_current = 32'h0000_1000; exc_opcode = 1'b1; exc_div0 = 1'b1;
    @(posedge clk); #1;
    exc_opcode = 1'b0; exc_div0 = 1'b0;
    observe(8, -10, 32'd253, b, m, ld, pw, bad);
    checks++;
    if (b != 4 || m != 3 || ld != 1 || bad != 0) begin
      errors++; $display("FAIL prio_seq: busy=%0d rd=%0d load=%0d badaddr=%0d expected 4 3 1 0", b, m, ld, bad);
    end
    checks++;
    if (exc_cause !== 2'b01 || epc_out !== 32'h0000_0FFC) begin
      errors++; $display("FAIL prio_cause: cause=%b epc=%h expected 01 00000ffc", exc_cause, epc_out);
    end
    $display("priority: cause=%b busy=%0d load=%0d", exc_cause, b, ld);
  endtask

  task automatic test_ignore_in_wait();
    int b, m, ld, pw, bad;
    @(negedge clk);
    pc_current = 32'h0000_0200; exc_overflow = 1'b1;
    @(posedge clk); #1;
    exc_overflow = 1'b0;
    observe(7, 1, 32'd254, b, m, ld, pw, bad);
    checks++;
    if (b != 4 || m != 3 || ld != 1 || pw != 1 || bad != 0) begin
      errors++; $display("FAIL wait_ignore: busy=%0d rd=%0d load=%0d wr=%0d badaddr=%0d expected 4 3 1 1 0", b, m, ld, pw, bad);
    end
    checks++;
    if (exc_cause !== 2'b10 || epc_out !== 32'h0000_01FC) begin
      errors++; $display("FAIL wait_cause: cause=%b epc=%h expected 10 000001fc", exc_cause, epc_out);
    end
    $display("wait_ignore: busy=%0d wr=%0d cause=%b", b, pw, exc_cause);
  endtask

  task automatic test_reset_mid();
    int b, m, ld, pw, bad;
    @(negedge clk);
    pc_current = 32'h0000_0100; exc_div0 = 1'b1;
    @(posedge clk); #1;
    exc_div0 = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    checks++;
    if (epc_out !== 32'h0000_00FC || busy !== 1'b1) begin
      errors++; $display("FAIL mid_pre: epc=%h busy=%b expected 000000fc 1", epc_out, busy);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (busy !== 1'b0 || mem_rd !== 1'b0 || epc_out !== 32'd0 || exc_cause !== 2'b00) begin
      errors++; $display("FAIL mid_reset: busy=%b rd=%b epc=%h cause=%b expected 0 0 0 00", busy, mem_rd, epc_out, exc_cause);
    end
    observe(5, -10, 32'd0, b, m, ld, pw, bad);
    checks++;
    if (ld != 0 || b != 0) begin
      errors++; $display("FAIL mid_noload: load=%0d busy=%0d expected 0 0", ld, b);
    end
    $display("reset_mid: busy=%b epc=%h load=%0d", busy, epc_out, ld);
  endtask

  task automatic test_wrap_and_return();
    int b, m, ld, pw, bad;
    @(negedge clk);
    pc_current = 32'd0; exc_div0 = 1'b1;
    @(posedge clk); #1;
    exc_div0 = 1'b0;
    observe(6, -10, 32'd255, b, m, ld, pw, bad);
    checks++;
    if (epc_out !== 32'hFFFF_FFFC || exc_cause !== 2'b11 || ld != 1 || bad != 0) begin
      errors++; $display("FAIL wrap_epc: epc=%h cause=%b load=%0d badaddr=%0d expected fffffffc 11 1 0", epc_out, exc_cause, ld, bad);
    end
    @(negedge clk);
    pc_current = 32'h0000_0800; pc_src_req = 3'b100; pc_write_req = 1'b1;
    #1;
    checks++;
    if (pc_src_sel !== 3'b100 || pc_write !== 1'b1) begin
      errors++; $display("FAIL eret_pass: sel=%b wr=%b expected 100 1", pc_src_sel, pc_write);
    end
    @(negedge clk); #1;
    pc_src_req = 3'b000; pc_write_req = 1'b0;
    checks++;
    if (epc_out !== 32'hFFFF_FFFC || exc_cause !== 2'b11) begin
      errors++; $display("FAIL eret_hold: epc=%h cause=%b expected fffffffc 11", epc_out, exc_cause);
    end
    $display("wrap_return: epc=%h cause=%b", epc_out, exc_cause);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    pc_current = 32'h0000_0300; exc_overflow = 1'b1;
    @(posedge clk); #1;
    exc_overflow = 1'b0;
    repeat (3) @(negedge clk);
    @(negedge clk); #1;
    checks++;
    if (pc_src_sel !== 3'b011 || pc_write !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL b2b_load: sel=%b wr=%b busy=%b expected 011 1 1", pc_src_sel, pc_write, busy);
    end
    @(negedge clk);
    pc_current = 32'h0000_0500; exc_opcode = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || pc_write !== 1'b0) begin
      errors++; $display("FAIL b2b_idle: busy=%b wr=%b expected 0 0", busy, pc_write);
    end
    @(posedge clk); #1;
    exc_opcode = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (busy !== 1'b1 || mem_rd !== 1'b1 || mem_addr !== 32'd253) begin
      errors++; $display("FAIL b2b_restart: busy=%b rd=%b addr=%0d expected 1 1 253", busy, mem_rd, mem_addr);
    end
    @(negedge clk); #1;
    checks++;
    if (epc_out !== 32'h0000_04FC || exc_cause !== 2'b01) begin
      errors++; $display("FAIL b2b_epc: epc=%h cause=%b expected 000004fc 01", epc_out, exc_cause);
    end
    $display("back_to_back: epc=%h cause=%b", epc_out, exc_cause);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_overflow();
    test_priority();
    test_ignore_in_wait();
    test_reset_mid();
    test_wrap_and_return();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
